instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader that writes instructions into the instruction memory and then lets the core start fetching. It takes a little-endian byte stream through a valid/ready handshake and packs it into `INSTR_LEN`-bit words. Each word goes out on the instruction memory write port at consecutive byte addresses, the same addresses the fetch stage later reads. `core_reset` holds the PC register and pipeline in reset until the image has loaded completely.

## Interface
Parameters:
- `SIZE`, 1024: instruction memory capacity, in instructions.
- `BASE`, `` `WORD'd0 ``: byte address of the first instruction written.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `byte_in` in 8: stream data byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader can accept a byte.
- `wr_en` out 1: instruction memory write strobe, one cycle per word.
- `wr_addr` out `` `WORD ``: byte address of the write.
- `wr_data` out `` `INSTR_LEN ``: instruction word.
- `core_reset` out 1: high holds the core in reset.
- `done` out 1: image loaded successfully.
- `error` out 1: load aborted.

## Operation
- A byte is accepted on any cycle where `byte_valid && byte_ready`.
- `byte_ready` is 1 in HDR, LOAD and CSUM, and 0 in DONE and ERROR.
- Stream format:
  - 2-byte count N, low byte first.
  - N×4 instruction bytes, each word least-significant byte first.
  - One checksum byte, only when the Configuration macro is set.
- States:
  - HDR: accepts 2 bytes, then decides:
    - N==0 → DONE (or CSUM when the macro is set).
    - N>SIZE → ERROR.
    - Otherwise → LOAD.
  - LOAD: 2-bit byte index plus 16-bit word counter k.
    - On the 4th byte of word k, register a write with `wr_data` = assembled word and `wr_addr` = BASE + 4k.
    - After word N−1 is written → DONE (or CSUM).
  - CSUM: see Configuration.
  - DONE: terminal until `reset`. `done`=1, `core_reset`=0.
  - ERROR: terminal until `reset`. `error`=1, `core_reset`=1.
- Reset values:
  - state=HDR, `byte_ready`=1.
  - `wr_en`=0, `wr_addr`=BASE, `wr_data`=0.
  - `core_reset`=1, `done`=0, `error`=0.
- A reset mid-load discards the partial word and the counters and returns to HDR. Words already written stay in memory. A new stream overwrites them from BASE.
- Address arithmetic is `` `WORD ``-bit, BASE + (k<<2), with no wrap check. BASE+4·SIZE must not overflow; this is an integration rule.
- No backpressure from memory: the write port accepts a write every cycle.

## Timing
- `wr_en` is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. `wr_addr` and `wr_data` are valid in that same cycle.
- Back-to-back bytes, one per cycle, are sustained: 4 cycles per instruction.
- `byte_valid` low stalls the counters; the partial word is held indefinitely.
- DONE is entered in the cycle after the final `wr_en` (or after the checksum byte is accepted).
  - `core_reset` falls and `done` rises in that first DONE cycle.
  - The core's first fetch happens on the next edge.
- For N==0 (no checksum), DONE is reached in the cycle after the 2nd header byte is accepted.
- `byte_ready` drops to 0 in the same cycle that DONE or ERROR is entered.
- ERROR is entered in the cycle after the byte that triggers it is accepted.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - After the last instruction, CSUM accepts one byte.
  - It is compared with the running XOR of all 4N instruction bytes, header bytes excluded. The XOR is 0 when N==0.
  - Match → DONE; mismatch → ERROR.
  - Writes already issued are not undone.
- Undefined:
  - No CSUM state and no XOR register.
  - The stream ends after the last instruction byte.
  - `error` is asserted only for N>SIZE.

## Structure
- `definitions.vh` provides:
  - `` `WORD `` and `` `INSTR_LEN ``.
  - New state encodings `` `LDR_HDR ``, `` `LDR_LOAD ``, `` `LDR_CSUM ``, `` `LDR_DONE ``, `` `LDR_ERROR ``.
  - `` `LDR_HDR_BYTES `` = 2.
- One sub-module, `byte_packer`:
  - Shifts bytes into a 32-bit little-endian word.
  - Pulses `word_ready` on the 4th byte.
  - Clears on `reset` or an explicit `clear`.
- The FSM, counters and the write-port register live in `instr_loader`.

## Test plan
- Stream 02 00, then 11 22 33 44, then AA BB CC DD:
  - Writes 0x44332211 @BASE, then 0xDDCCBBAA @BASE+4, each `wr_en` one cycle after the 4th byte.
  - `done`=1 and `core_reset`=0 in the cycle after the second write.
- Header 00 00 → DONE with no `wr_en` (macro off).
- Header with N=SIZE+1 → `error`=1, `byte_ready`=0, `core_reset` stays 1, no writes.
- `byte_valid` toggled randomly across a 3-word image → the same words and addresses as the back-to-back case.
- `reset` pulsed after 6 bytes of an image, then a fresh 1-word image 01 00 EF BE AD DE → single write 0xDEADBEEF @BASE.
- Macro on:
  - Image 01 00 01 02 03 04 with checksum 04 → DONE.
  - Same image with checksum 05 → ERROR after the write of 0x04030201.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// ============================================================================
//  Module      : instr_loader_pkg
//  Description : Shared widths, loader state encodings and address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INSTR_LOADER_DEFS
`define INSTR_LOADER_DEFS
`define WORD          32
`define INSTR_LEN     32
`define LDR_HDR       3'd0
`define LDR_LOAD      3'd1
`define LDR_CSUM      3'd2
`define LDR_DONE      3'd3
`define LDR_ERROR     3'd4
`define LDR_HDR_BYTES 2
`endif

package instr_loader_pkg;

   typedef enum logic [2:0] {
      ST_HDR   = `LDR_HDR,
      ST_LOAD  = `LDR_LOAD,
      ST_CSUM  = `LDR_CSUM,
      ST_DONE  = `LDR_DONE,
      ST_ERROR = `LDR_ERROR
   } ldr_state_t;

   localparam int HDR_BYTES = `LDR_HDR_BYTES;

   function automatic logic [`WORD-1:0] word_addr(input logic [`WORD-1:0] base,
                                                  input logic [15:0]       k);
      return base + {{(`WORD-18){1'b0}}, k, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
// ============================================================================
//  Module      : byte_packer
//  Description : Packs a little-endian byte stream into 32-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_en,
   output logic [31:0] packed_word,
   output logic        word_ready
);

   logic [1:0]  idx;
   logic [23:0] partial;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx     <= 2'd0;
         partial <= 24'd0;
      end else if (byte_en) begin
         idx     <= idx + 2'd1;
         partial <= {byte_in, partial[23:8]};
      end
   end

   // The 4th byte completes the word combinationally so the caller can register it.
   assign packed_word = {byte_in, partial};
   assign word_ready  = byte_en && (idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  Module      : instr_loader
//  Description : Boot-time loader writing a byte-stream image into instruction
//                memory; optional trailing XOR checksum via INSTR_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int               SIZE = 1024,
   parameter logic [`WORD-1:0] BASE = `WORD'd0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  wr_en,
   output logic [`WORD-1:0]      wr_addr,
   output logic [`INSTR_LEN-1:0] wr_data,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error
);

`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam ldr_state_t FIN_STATE = ST_CSUM;
   logic [7:0] csum;
`else
   localparam ldr_state_t FIN_STATE = ST_DONE;
`endif

   ldr_state_t  state, state_nxt;
   logic        hdr_idx;
   logic [7:0]  lo_byte;
   logic [15:0] count;
   logic [15:0] k;
   logic        accept, hdr_last, all_written, pack_en, word_ready;
   logic [15:0] hdr_n;
   logic [31:0] packed_word;

   assign accept      = byte_valid && byte_ready;
   assign hdr_last    = (hdr_idx == 1'(HDR_BYTES - 1));
   assign hdr_n       = {byte_in, lo_byte};
   assign all_written = (k == count);
   assign pack_en     = accept && (state == ST_LOAD) && !all_written;

   byte_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .clear       (state != ST_LOAD),
      .byte_in     (byte_in),
      .byte_en     (pack_en),
      .packed_word (packed_word),
      .word_ready  (word_ready)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_HDR;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      core_reset = 1'b1;
      case (state)
         ST_HDR: begin
            byte_ready = 1'b1;
            if (accept && hdr_last) begin
               if (hdr_n == 16'd0)                 state_nxt = FIN_STATE;
               else if ({16'd0, hdr_n} > 32'(SIZE)) state_nxt = ST_ERROR;
               else                                state_nxt = ST_LOAD;
            end
         end
         // Leave LOAD only once the last write is on the port, so DONE follows it.
         ST_LOAD: begin
            byte_ready = 1'b1;
            if (all_written) state_nxt = FIN_STATE;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            byte_ready = 1'b1;
            if (accept) state_nxt = (byte_in == csum) ? ST_DONE : ST_ERROR;
         end
`endif
         ST_DONE: begin
            done       = 1'b1;
            core_reset = 1'b0;
         end
         ST_ERROR: error = 1'b1;
         default:  state_nxt = ST_HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_idx <= 1'b0;
         lo_byte <= 8'd0;
         count   <= 16'd0;
         k       <= 16'd0;
         wr_en   <= 1'b0;
         wr_addr <= BASE;
         wr_data <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum    <= 8'd0;
`endif
      end else begin
         wr_en <= word_ready;
         if (state == ST_HDR && accept) begin
            hdr_idx <= ~hdr_idx;
            if (!hdr_last) lo_byte <= byte_in;
            else begin
               count <= hdr_n;
               k     <= 16'd0;
            end
         end
         if (word_ready) begin
            wr_data <= packed_word;
            wr_addr <= word_addr(BASE, k);
            k       <= k + 16'd1;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         if (pack_en) csum <= csum ^ byte_in;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Scoreboard bench for instr_loader (directed image streams).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

   localparam int          SIZE = 4;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk, reset, byte_valid, byte_ready, wr_en, core_reset, done, error;
   logic [7:0]  byte_in;
   logic [31:0] wr_addr, wr_data;

   instr_loader #(.SIZE(SIZE), .BASE(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t        sb[$];
   int         total = 0;
   int         bad   = 0;
   int         acc_cyc;
   logic [7:0] xr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (wr_en) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic send(input logic [7:0] b, input int idle);
      int t;
      repeat (idle) begin
         byte_valid = 1'b0;
         @(posedge clk); #1;
      end
      byte_in    = b;
      byte_valid = 1'b1;
      t = 0;
      while (!byte_ready && t < 10) begin
         @(posedge clk); #1;
         t++;
      end
      if (!byte_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: byte_ready got 0 expected 1");
      end else begin
         @(posedge clk); #1;
         acc_cyc = cyc;
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int k, input bit rnd);
      wr_t e;
      for (int i = 0; i < 4; i++) send(w[8*i +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
      e.addr = BASE + 32'(k) * 32'd4;
      e.data = w;
      e.cyc  = acc_cyc;
      sb.push_back(e);
      xr = xr ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      byte_valid = 1'b0;
      xr         = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(posedge clk);
      #1;
      chk("writes_outstanding", 32'(sb.size()), 32'd0);
   endtask

   task automatic finish_ok();
`ifdef INSTR_LOADER_CHECKSUM_EN
      send(xr, 0);
`else
      int t;
      t = 0;
      while (!done && t < 5) begin
         @(posedge clk); #1;
         t++;
      end
`endif
      chk("done", 32'(done), 32'd1);
      chk("core_reset", 32'(core_reset), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      byte_in    = 8'd0;
      byte_valid = 1'b0;
      xr         = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_byte_ready", 32'(byte_ready), 32'd1);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", wr_addr, BASE);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      reset = 1'b0;

      // two back-to-back words
      send(8'h02, 0); send(8'h00, 0);
      send_word(32'h44332211, 0, 0);
      send_word(32'hDDCCBBAA, 1, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk("csum_wait_done", 32'(done), 32'd0);
      send(8'h44, 0);
      chk("two_word_done", 32'(done), 32'd1);
`else
      chk("write_cycle_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("two_word_done", 32'(done), 32'd1);
      chk("two_word_core_reset", 32'(core_reset), 32'd0);
      chk("two_word_byte_ready", 32'(byte_ready), 32'd0);
`endif
      drain();

      // empty image
      do_reset();
      send(8'h00, 0); send(8'h00, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk("empty_done_pre", 32'(done), 32'd0);
      send(8'h00, 0);
`endif
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_byte_ready", 32'(byte_ready), 32'd0);
      drain();

      // oversize header
      do_reset();
      send(8'(SIZE + 1), 0); send(8'h00, 0);
      chk("over_error", 32'(error), 32'd1);
      chk("over_byte_ready", 32'(byte_ready), 32'd0);
      chk("over_core_reset", 32'(core_reset), 32'd1);
      chk("over_done", 32'(done), 32'd0);
      drain();

      // stalled stream
      do_reset();
      send(8'h03, 1); send(8'h00, 2);
      send_word(32'h12345678, 0, 1);
      send_word(32'h9ABCDEF0, 1, 1);
      send_word(32'h0F1E2D3C, 2, 1);
      finish_ok();
      drain();

      // reset mid-load then fresh image
      do_reset();
      send(8'h03, 0); send(8'h00, 0);
      send_word(32'h44332211, 0, 0);
      send(8'h55, 0); send(8'h66, 0);
      do_reset();
      drain();
      send(8'h01, 0); send(8'h00, 0);
      send_word(32'hDEADBEEF, 0, 0);
      finish_ok();
      drain();

`ifdef INSTR_LOADER_CHECKSUM_EN
      do_reset();
      send(8'h01, 0); send(8'h00, 0);
      send_word(32'h04030201, 0, 0);
      send(8'h04, 0);
      chk("csum_ok_done", 32'(done), 32'd1);
      drain();

      do_reset();
      send(8'h01, 0); send(8'h00, 0);
      send_word(32'h04030201, 0, 0);
      send(8'h05, 0);
      chk("csum_bad_error", 32'(error), 32'd1);
      chk("csum_bad_done", 32'(done), 32'd0);
      chk("csum_bad_core_reset", 32'(core_reset), 32'd1);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
